adder_share_arb: RTL and testbench
==================================

// Module: adder_share_arb
// PURPOSE
//   Shares one registered WIDTH-bit adder (x + y + cin -> WIDTH+1 bits, plus a zero flag) among NREQ requesters.
//   Arbitration is round-robin; one operation is in flight at a time.
//   Each requester uses a valid/ready request port; results return on one valid/ready response port tagged with the requester id.
//   Sits between client blocks and the arithmetic datapath.
// PARAMETERS
//   WIDTH   32              operand width
//   SWIDTH  WIDTH+1         sum width (carry included)
//   NREQ    4               number of requesters, 2..16
//   IDW     $clog2(NREQ)    requester id width
// PORTS
//   clk        in   1             clock, all state on rising edge
//   rst_n      in   1             asynchronous active-low reset
//   req_valid  in   NREQ          request present, bit i = requester i
//   req_ready  out  NREQ          one-hot grant/accept, bit i = requester i
//   req_x      in   NREQ*WIDTH    operand x, slice i = requester i
//   req_y      in   NREQ*WIDTH    operand y, slice i = requester i
//   req_cin    in   NREQ          carry-in per requester
//   rsp_valid  out  1             result available
//   rsp_ready  in   1             consumer accepts result
//   rsp_id     out  IDW           index of the requester that owns the result
//   rsp_sum    out  SWIDTH        x + y + cin, zero-extended, no overflow loss
//   rsp_zero   out  1             rsp_sum == 0
//   busy       out  1             state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n low):
//     - state=IDLE; rsp_valid=0, rsp_sum=0, rsp_id=0, rsp_zero=0, busy=0.
//     - last_grant=NREQ-1, so requester 0 has first priority.
//   FSM states IDLE -> CALC -> RESP -> IDLE.
//   IDLE:
//     - req_ready is combinational and asserted only in IDLE.
//     - Grant g = first i with req_valid[i], searching from last_grant+1 and wrapping mod NREQ.
//     - req_ready[g]=1 and all other bits 0. No request means req_ready=0 and state stays IDLE.
//     - On grant: latch x, y, cin and g; last_grant<=g; go to CALC.
//   CALC: one cycle. Register sum=x+y+cin at SWIDTH width, zero=(sum==0) and id=g. Go to RESP.
//   RESP:
//     - rsp_valid=1. rsp_sum, rsp_id and rsp_zero stay stable until rsp_valid && rsp_ready.
//     - On that handshake: rsp_valid<=0 and go to IDLE.
//     - Stalls indefinitely on rsp_ready=0. No requests are accepted while stalled.
//   Latency and throughput:
//     - Request accepted in cycle t -> rsp_valid high from cycle t+2.
//     - With rsp_ready=1 the peak rate is one operation per 3 cycles.
//   Requester rules:
//     - Operands are sampled only in the accept cycle; later changes are ignored.
//     - A requester whose valid drops before it is granted is not served.
//     - req_valid is not required to be held stable.
//   Boundary cases:
//     - All requesters valid: served in order 0,1,2,3,0,...
//     - Only one valid: it is served every opportunity regardless of the pointer.
//     - x=y=all-ones with cin=1: sum=2^SWIDTH-1.
//     - x=y=0 with cin=0: sum=0 and zero=1.
//     - Reset asserted mid-operation: the in-flight operation is dropped with no response, and priority returns to requester 0.
// TESTING
//   1. Reset, then req_valid=0001, x0=5, y0=7, cin0=1.
//      -> req_ready=0001 that cycle; rsp_valid at t+2 with id=0, sum=13, zero=0.
//   2. WIDTH=32, x=y=0xFFFFFFFF, cin=1 -> rsp_sum=0x1_FFFFFFFF, zero=0.
//      x=y=0, cin=0 -> sum=0, zero=1.
//   3. req_valid=1111 held for 8 operations, rsp_ready=1.
//      -> ids 0,1,2,3,0,1,2,3; accepts spaced exactly 3 cycles apart.
//   4. rsp_ready=0 for 10 cycles in RESP.
//      -> rsp_* stable and req_ready=0 throughout; accept resumes the cycle after the handshake.
//   5. Grant to requester 2, then assert rst_n=0 in CALC.
//      -> rsp_valid never rises; after release with req_valid=1111 the first grant goes to 0.
//   6. Only requester 3 valid, repeated 4 times -> every grant goes to 3, ids all 3.

Source files
------------

// File: rtl/adder_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : adder_share_arb
//  Purpose  : Shares one registered WIDTH-bit adder (x + y + cin) among NREQ
//             requesters using round-robin arbitration. One operation is in
//             flight at a time; results return on a single valid/ready
//             response port tagged with the owning requester id.
//  Ports    : clk, rst_n               clock / async active-low reset
//             req_valid/req_ready      per-requester request handshake
//             req_x/req_y/req_cin      per-requester operands (sliced)
//             rsp_valid/rsp_ready      response handshake
//             rsp_id/rsp_sum/rsp_zero  response payload
//             busy                     high whenever not idle
//  Revision : 1.0  initial release
// ============================================================================
module adder_share_arb #(
  parameter int WIDTH  = 32,
  parameter int SWIDTH = WIDTH + 1,
  parameter int NREQ   = 4,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [SWIDTH-1:0]     rsp_sum,
  output logic                  rsp_zero,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [IDW-1:0]    r_last_grant;
  logic [IDW-1:0]    r_gid;
  logic [WIDTH-1:0]  r_x;
  logic [WIDTH-1:0]  r_y;
  logic              r_cin;

  logic              w_found;
  logic [IDW-1:0]    w_grant;
  logic [SWIDTH-1:0] w_sum;

  // Round-robin search: start one past the last winner and wrap, so the
  // most recently served requester has the lowest priority next time.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(r_last_grant) + k) % NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_grant = IDW'(idx);
      end
    end
  end

  // Grant is only visible while idle; the accept happens in that same cycle.
  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_found) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  assign w_sum = SWIDTH'(r_x) + SWIDTH'(r_y) + SWIDTH'(r_cin);
  assign busy  = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= IDW'(NREQ - 1);
      r_gid        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_cin        <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_sum      <= '0;
      rsp_id       <= '0;
      rsp_zero     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_x          <= req_x[w_grant*WIDTH +: WIDTH];
            r_y          <= req_y[w_grant*WIDTH +: WIDTH];
            r_cin        <= req_cin[w_grant];
            r_gid        <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= S_CALC;
          end
        end
        S_CALC: begin
          rsp_sum   <= w_sum;
          rsp_zero  <= (w_sum == '0);
          rsp_id    <= r_gid;
          rsp_valid <= 1'b1;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          // Payload registers are left untouched so they hold while stalled.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_share_arb
//  Purpose  : Self-checking bench for adder_share_arb. A transaction-level
//             model predicts grants and responses every cycle; directed
//             scenarios additionally pin observed results to literal values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_share_arb;

  localparam int WIDTH  = 32;
  localparam int SWIDTH = WIDTH + 1;
  localparam int NREQ   = 4;
  localparam int IDW    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [SWIDTH-1:0]     rsp_sum;
  logic                  rsp_zero;
  logic                  busy;

  adder_share_arb #(.WIDTH(WIDTH), .SWIDTH(SWIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_zero(rsp_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Transaction-level model: one job at most, aged in cycles since accept.
  bit              m_busy = 1'b0;
  int              m_age  = 0;
  int              m_last = NREQ - 1;
  longint unsigned m_sum  = 0;
  int              m_id   = 0;

  // Observation logs for the directed literal checks.
  int              acc_id[$];
  int              acc_cyc[$];
  int              rsp_id_q[$];
  longint unsigned rsp_sum_q[$];
  int              rsp_zero_q[$];
  int              rsp_cyc_q[$];

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: inputs already applied; check at negedge, advance model.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = NREQ - 1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_sum", rsp_sum, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_zero", rsp_zero, 0);
    end else begin
      int              pick;
      logic [NREQ-1:0] e_ready;
      bit              e_rv;
      pick    = -1;
      e_ready = '0;
      if (!m_busy) begin
        for (int k = 1; k <= NREQ; k++) begin
          int i;
          i = (m_last + k) % NREQ;
          if (pick < 0 && req_valid[i]) pick = i;
        end
        if (pick >= 0) e_ready[pick] = 1'b1;
      end
      e_rv = m_busy && (m_age >= 2);

      chk("req_ready", req_ready, e_ready);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("busy", busy, m_busy);
      if (e_rv) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_sum", rsp_sum, m_sum);
        chk("rsp_zero", rsp_zero, (m_sum == 0));
      end

      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && req_valid[i]) begin
          acc_id.push_back(i);
          acc_cyc.push_back(cyc);
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_id_q.push_back(int'(rsp_id));
        rsp_sum_q.push_back(64'(rsp_sum));
        rsp_zero_q.push_back(int'(rsp_zero));
        rsp_cyc_q.push_back(cyc);
      end

      if (m_busy) begin
        if (e_rv && rsp_ready) m_busy = 1'b0;
        else m_age++;
      end else if (pick >= 0) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_id   = pick;
        m_last = pick;
        m_sum  = longint'(req_x[pick*WIDTH +: WIDTH]) + longint'(req_y[pick*WIDTH +: WIDTH])
               + longint'(req_cin[pick]);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_handshake(int max_cycles);
    int n0;
    int k;
    n0 = rsp_cyc_q.size();
    k  = 0;
    while (rsp_cyc_q.size() == n0 && k < max_cycles) begin
      tick();
      k++;
    end
    if (rsp_cyc_q.size() == n0) chk("handshake_timeout", rsp_cyc_q.size() - n0, 1);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*WIDTH +: WIDTH] = $urandom();
      req_y[i*WIDTH +: WIDTH] = $urandom();
      req_cin[i]              = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset(int n);
    req_valid = '0;
    rst_n     = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int rbase;
    int k;

    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    do_reset(3);

    // Scenario 1: single request from requester 0.
    req_valid         = 4'b0001;
    req_x[0 +: WIDTH] = 32'd5;
    req_y[0 +: WIDTH] = 32'd7;
    req_cin[0]        = 1'b1;
    tick();
    req_valid = '0;
    req_x[0 +: WIDTH] = 32'd100;  // late change must be ignored
    wait_handshake(10);
    chk("s1_grant_id", acc_id[0], 0);
    chk("s1_latency", rsp_cyc_q[0] - acc_cyc[0], 2);
    chk("s1_sum", rsp_sum_q[0], 13);
    chk("s1_id", rsp_id_q[0], 0);
    chk("s1_zero", rsp_zero_q[0], 0);

    // Scenario 2: carry-out and zero extremes.
    req_valid             = 4'b0010;
    req_x[WIDTH +: WIDTH] = 32'hFFFF_FFFF;
    req_y[WIDTH +: WIDTH] = 32'hFFFF_FFFF;
    req_cin[1]            = 1'b1;
    tick();
    req_valid = '0;
    wait_handshake(10);
    chk("s2_max_sum", rsp_sum_q[rsp_sum_q.size()-1], 64'h1_FFFF_FFFF);
    chk("s2_max_zero", rsp_zero_q[rsp_zero_q.size()-1], 0);
    chk("s2_max_id", rsp_id_q[rsp_id_q.size()-1], 1);
    req_valid               = 4'b0100;
    req_x[2*WIDTH +: WIDTH] = '0;
    req_y[2*WIDTH +: WIDTH] = '0;
    req_cin[2]              = 1'b0;
    tick();
    req_valid = '0;
    wait_handshake(10);
    chk("s2_zero_sum", rsp_sum_q[rsp_sum_q.size()-1], 0);
    chk("s2_zero_flag", rsp_zero_q[rsp_zero_q.size()-1], 1);

    // Scenario 3: all requesters valid for 8 operations after reset.
    do_reset(2);
    base      = acc_id.size();
    req_valid = 4'b1111;
    k         = 0;
    while (acc_id.size() < base + 8 && k < 40) begin
      rand_ops();
      tick();
      k++;
    end
    req_valid = '0;
    wait_handshake(10);
    chk("s3_accept_count", acc_id.size() - base, 8);
    for (int i = 0; i < 8 && base + i < acc_id.size(); i++) begin
      chk("s3_rr_order", acc_id[base+i], i % 4);
      if (i > 0) chk("s3_spacing", acc_cyc[base+i] - acc_cyc[base+i-1], 3);
    end

    // Scenario 4: response stalled for 10 cycles while others request.
    rand_ops();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    tick();
    base      = acc_id.size();
    req_valid = 4'b1111;
    repeat (11) tick();
    chk("s4_no_accept_in_stall", acc_id.size() - base, 0);
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("s4_resume_accept", acc_cyc[acc_cyc.size()-1], rsp_cyc_q[rsp_cyc_q.size()-1] + 1);
    chk("s4_next_grant", acc_id[acc_id.size()-1], 1);
    req_valid = '0;
    wait_handshake(10);

    // Scenario 5: reset while requester 2's operation is in CALC.
    rand_ops();
    req_valid = 4'b0100;
    tick();
    chk("s5_grant_2", acc_id[acc_id.size()-1], 2);
    rbase     = rsp_cyc_q.size();
    req_valid = '0;
    rst_n     = 1'b0;
    repeat (2) tick();
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    tick();
    chk("s5_first_grant", acc_id[acc_id.size()-1], 0);
    chk("s5_dropped", rsp_cyc_q.size() - rbase, 0);
    req_valid = '0;
    wait_handshake(10);

    // Scenario 6: only requester 3 valid, four operations.
    base      = acc_id.size();
    req_valid = 4'b1000;
    k         = 0;
    while (acc_id.size() < base + 4 && k < 30) begin
      rand_ops();
      tick();
      k++;
    end
    req_valid = '0;
    wait_handshake(10);
    chk("s6_accept_count", acc_id.size() - base, 4);
    for (int i = base; i < acc_id.size(); i++) chk("s6_grant_3", acc_id[i], 3);

    // Randomized traffic with random back-pressure.
    for (int n = 0; n < 400; n++) begin
      rand_ops();
      if ($urandom_range(0, 9) == 0) begin
        req_x[0 +: WIDTH] = 32'hFFFF_FFFF;
        req_y[0 +: WIDTH] = 32'hFFFF_FFFF;
      end
      req_valid = 4'($urandom());
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
